// File: rtl/disp_pkg.sv
// Shared definitions for the seven-segment address display controller.
package disp_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    COMMIT  = 2'd2
  } state_t;

  localparam int          NUM_DIGITS  = 4;
  localparam logic [15:0] BCD_SAT     = 16'h9999;
  localparam logic [6:0]  SEG_BLANK   = 7'h00;
  localparam logic [3:0]  ADD3_THRESH = 4'd5;

endpackage

// File: rtl/display_decoder.sv
// BCD digit to active-high seven-segment pattern, seg = {g,f,e,d,c,b,a}.
module display_decoder (
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    case (digit)
      4'd0:    seg = 7'h3F;
      4'd1:    seg = 7'h06;
      4'd2:    seg = 7'h5B;
      4'd3:    seg = 7'h4F;
      4'd4:    seg = 7'h66;
      4'd5:    seg = 7'h6D;
      4'd6:    seg = 7'h7D;
      4'd7:    seg = 7'h07;
      4'd8:    seg = 7'h7F;
      4'd9:    seg = 7'h6F;
      default: seg = 7'h00;
    endcase
  end

endmodule

// File: rtl/display_scan_controller.sv
// Binary-to-BCD (double-dabble) address display with a multiplexed 4-digit scan.
// Optional LEADING_ZERO_BLANK_EN blanks leading zero digits above the units.
module display_scan_controller
  import disp_pkg::*;
#(
  parameter int ADDR_W   = 15,
  parameter int SCAN_DIV = 50000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] address,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [15:0]       bcd_out,
  output logic [6:0]        seg,
  output logic [3:0]        digit_sel
);

  localparam int ACC_W = 4 * (NUM_DIGITS + 1);
  localparam int CNT_W = $clog2(ADDR_W + 1);
  localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  state_t            state;
  logic [ADDR_W-1:0] shreg;
  logic [ACC_W-1:0]  acc;
  logic [CNT_W-1:0]  shift_cnt;
  logic [ACC_W-1:0]  acc_adj;
  logic [ACC_W-1:0]  acc_next;
  logic [ADDR_W-1:0] shreg_next;
  logic              last_shift;
  logic              accept;

  logic [PRE_W-1:0]  presc;
  logic [1:0]        idx;
  logic [3:0]        cur_nib;
  logic [6:0]        dec_seg;

  function automatic logic [ACC_W-1:0] dabble_adj(input logic [ACC_W-1:0] a);
    logic [ACC_W-1:0] r;
    for (int i = 0; i < NUM_DIGITS + 1; i++) begin
      r[4*i +: 4] = (a[4*i +: 4] >= ADD3_THRESH) ? a[4*i +: 4] + 4'd3 : a[4*i +: 4];
    end
    return r;
  endfunction

  always_comb begin
    acc_adj                = dabble_adj(acc);
    {acc_next, shreg_next} = {acc_adj, shreg} << 1;
  end

  assign last_shift = (shift_cnt == CNT_W'(ADDR_W - 1));
  assign accept     = in_valid && in_ready;

  // Control: the commit registers load on the final shift edge so done and
  // the new bcd_out are both visible during the COMMIT cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      overflow  <= 1'b0;
      bcd_out   <= 16'h0000;
      shift_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (accept) begin
            shift_cnt <= '0;
            in_ready  <= 1'b0;
            busy      <= 1'b1;
            state     <= CONVERT;
          end
        end
        CONVERT: begin
          shift_cnt <= shift_cnt + 1'b1;
          if (last_shift) begin
            done  <= 1'b1;
            state <= COMMIT;
            if (acc_next[ACC_W-1 -: 4] != 4'd0) begin
              bcd_out  <= BCD_SAT;
              overflow <= 1'b1;
            end else begin
              bcd_out  <= acc_next[15:0];
              overflow <= 1'b0;
            end
          end
        end
        COMMIT: begin
          done     <= 1'b0;
          busy     <= 1'b0;
          in_ready <= 1'b1;
          state    <= IDLE;
        end
        default: begin
          done     <= 1'b0;
          busy     <= 1'b0;
          in_ready <= 1'b1;
          state    <= IDLE;
        end
      endcase
    end
  end

  // Datapath: shift register and BCD accumulator carry no reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && accept) begin
      shreg <= address;
      acc   <= '0;
    end else if (state == CONVERT) begin
      shreg <= shreg_next;
      acc   <= acc_next;
    end
  end

  // Scan: free-running prescaler and digit index, independent of the FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc     <= '0;
      idx       <= 2'd0;
      digit_sel <= 4'b0001;
    end else if (presc == PRE_W'(SCAN_DIV - 1)) begin
      presc     <= '0;
      idx       <= idx + 2'd1;
      digit_sel <= {digit_sel[2:0], digit_sel[3]};
    end else begin
      presc <= presc + 1'b1;
    end
  end

  assign cur_nib = bcd_out[4*idx +: 4];

  display_decoder u_decoder (
    .digit (cur_nib),
    .seg   (dec_seg)
  );

`ifdef LEADING_ZERO_BLANK_EN
  logic blank;

  always_comb begin
    case (idx)
      2'd3:    blank = (bcd_out[15:12] == 4'd0);
      2'd2:    blank = (bcd_out[15:8]  == 8'd0);
      2'd1:    blank = (bcd_out[15:4]  == 12'd0);
      default: blank = 1'b0;
    endcase
    seg = blank ? SEG_BLANK : dec_seg;
  end
`else
  assign seg = dec_seg;
`endif

endmodule

// File: tb/tb_display_scan_controller.sv
// Randomized self-checking bench for display_scan_controller with a decimal reference model.
module tb_display_scan_controller;

  localparam int ADDR_W   = 15;
  localparam int SCAN_DIV = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] address;
  logic              busy;
  logic              done;
  logic              overflow;
  logic [15:0]       bcd_out;
  logic [6:0]        seg;
  logic [3:0]        digit_sel;

  int n_cmp = 0;
  int n_err = 0;
  int ecount = 0;
  int exp_val = 0;

  display_scan_controller #(.ADDR_W(ADDR_W), .SCAN_DIV(SCAN_DIV)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .address   (address),
    .busy      (busy),
    .done      (done),
    .overflow  (overflow),
    .bcd_out   (bcd_out),
    .seg       (seg),
    .digit_sel (digit_sel)
  );

  always #5 clk = ~clk;

  // Clock edges since the last reset edge; the scan position follows from it.
  always @(posedge clk) begin
    if (reset) ecount <= 0;
    else       ecount <= ecount + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
      4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
      8: return 7'h7F;  9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  function automatic int sat(input int v);
    return (v > 9999) ? 9999 : v;
  endfunction

  function automatic logic [15:0] bcd_of(input int v);
    logic [15:0] r;
    r = {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    return r;
  endfunction

  function automatic logic [6:0] exp_seg(input int val, input int i);
    int div;
    div = (i == 0) ? 1 : (i == 1) ? 10 : (i == 2) ? 100 : 1000;
`ifdef LEADING_ZERO_BLANK_EN
    if (i > 0 && val < div) return 7'h00;
`endif
    return seg_of((val / div) % 10);
  endfunction

  // Called at the negedge of the first cycle after the accept edge.
  task automatic watch_conv(input int a);
    int v;
    v = sat(a);
    for (int k = 1; k <= 16; k++) begin
      if (k < 16) begin
        n_cmp++;
        if (done !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b1 || bcd_out !== bcd_of(exp_val)) begin
          n_err++;
          $display("FAIL conv_busy a=%0d k=%0d: done=%b in_ready=%b busy=%b bcd=%h, required 0 0 1 %h",
                   a, k, done, in_ready, busy, bcd_out, bcd_of(exp_val));
        end
      end else begin
        n_cmp++;
        if (done !== 1'b1 || bcd_out !== bcd_of(v) || overflow !== (a > 9999)) begin
          n_err++;
          $display("FAIL conv_done a=%0d: done=%b bcd=%h ovf=%b, required 1 %h %b",
                   a, done, bcd_out, overflow, bcd_of(v), (a > 9999));
        end
      end
      @(negedge clk);
    end
    n_cmp++;
    if (in_ready !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL conv_idle a=%0d: in_ready=%b done=%b busy=%b, required 1 0 0",
               a, in_ready, done, busy);
    end
    exp_val = v;
  endtask

  task automatic run_conv(input int a);
    in_valid = 1'b1;
    address  = ADDR_W'(a);
    @(negedge clk);
    in_valid = 1'b0;
    watch_conv(a);
  endtask

  task automatic check_scan(input int cycles);
    int i;
    for (int c = 0; c < cycles; c++) begin
      i = (ecount / SCAN_DIV) % 4;
      n_cmp++;
      if (digit_sel !== 4'(1 << i) || seg !== exp_seg(exp_val, i)) begin
        n_err++;
        $display("FAIL scan val=%0d c=%0d: digit_sel=%b seg=%h, required %b %h",
                 exp_val, c, digit_sel, seg, 4'(1 << i), exp_seg(exp_val, i));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    reset    = 1'b1;
    in_valid = 1'b0;
    address  = '0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (digit_sel !== 4'b0001 || bcd_out !== 16'h0000 || in_ready !== 1'b1 || busy !== 1'b0 ||
        done !== 1'b0 || overflow !== 1'b0 || seg !== seg_of(0)) begin
      n_err++;
      $display("FAIL reset_vals: sel=%b bcd=%h rdy=%b busy=%b done=%b ovf=%b seg=%h, required 0001 0000 1 0 0 0 %h",
               digit_sel, bcd_out, in_ready, busy, done, overflow, seg, seg_of(0));
    end
    reset = 1'b0;
    exp_val = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      n_cmp++;
      if (done !== 1'b0 || in_ready !== 1'b1) begin
        n_err++;
        $display("FAIL reset_idle c=%0d: done=%b in_ready=%b, required 0 1", c, done, in_ready);
      end
    end
  endtask

  task automatic test_basic;
    run_conv(1234);
    check_scan(16);
  endtask

  task automatic test_overflow;
    run_conv(32767);
    check_scan(8);
    run_conv(42);
    check_scan(20);
  endtask

  task automatic test_scan;
    run_conv(5678);
    check_scan(24);
  endtask

  task automatic test_back_to_back;
    in_valid = 1'b1;
    address  = ADDR_W'(9999);
    @(negedge clk);
    address  = ADDR_W'(1111);
    watch_conv(9999);
    @(negedge clk);
    in_valid = 1'b0;
    watch_conv(1111);
  endtask

  task automatic test_reset_abort;
    in_valid = 1'b1;
    address  = ADDR_W'(5000);
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 1; k < 8; k++) begin
      n_cmp++;
      if (done !== 1'b0) begin
        n_err++;
        $display("FAIL abort_pre k=%0d: done=%b, required 0", k, done);
      end
      @(negedge clk);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_val = 0;
    n_cmp++;
    if (done !== 1'b0 || bcd_out !== 16'h0000 || digit_sel !== 4'b0001 || in_ready !== 1'b1 ||
        busy !== 1'b0 || overflow !== 1'b0) begin
      n_err++;
      $display("FAIL abort_state: done=%b bcd=%h sel=%b rdy=%b busy=%b ovf=%b, required 0 0000 0001 1 0 0",
               done, bcd_out, digit_sel, in_ready, busy, overflow);
    end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      n_cmp++;
      if (done !== 1'b0 || bcd_out !== 16'h0000) begin
        n_err++;
        $display("FAIL abort_post c=%0d: done=%b bcd=%h, required 0 0000", c, done, bcd_out);
      end
    end
  endtask

  task automatic test_random;
    int a;
    for (int n = 0; n < 8; n++) begin
      a = (n == 0) ? 10000 : (n == 1) ? 9999 : (n == 2) ? 0 : int'($urandom_range(0, 32767));
      run_conv(a);
      check_scan(int'($urandom_range(1, 6)));
    end
    check_scan(16);
  endtask

  initial begin
    test_reset;
    test_basic;
    test_overflow;
    test_scan;
    test_back_to_back;
    test_reset_abort;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/display_scan_controller.md
Name: display_scan_controller

Overview:
- Sequencing controller for the 4-digit seven-segment address display.
- Accepts a 15-bit address over a valid/ready handshake and converts it to BCD iteratively (double-dabble), one shift per cycle, with no divide/multiply logic.
- Time-multiplexes one shared display_decoder across four digits, driving a one-hot digit select.
- Sits between the address source (tester core) and the board's 7-segment pins.

Parameters:
- ADDR_W, 15, width of the input address; the shift count equals ADDR_W.
- SCAN_DIV, 50000, clk cycles per digit slot; legal range >= 1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  address valid.
- in_ready  output  1  controller can accept an address (IDLE only).
- address  input  ADDR_W  binary address to display.
- busy  output  1  conversion in progress (CONVERT or COMMIT).
- done  output  1  one-cycle pulse when the displayed value updates.
- overflow  output  1  last committed address > 9999.
- bcd_out  output  16  committed BCD digits {thousands, hundreds, tens, units}.
- seg  output  7  segment pattern for the currently selected digit.
- digit_sel  output  4  one-hot digit enable; bit0 = units.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous, active-high and takes priority over all other activity.
- Reset values:
  - State = IDLE; in_ready = 1; busy = 0; done = 0; overflow = 0.
  - bcd_out = 16'h0000.
  - Scan index = 0; prescaler = 0; digit_sel = 4'b0001.
  - seg = decoder output for digit 0.
- FSM states IDLE, CONVERT, COMMIT:
  - IDLE: in_ready = 1. When in_valid = 1, capture address into the shift register, clear the 20-bit BCD accumulator (5 digits) and the shift counter, then go to CONVERT.
  - CONVERT: each cycle, add 3 to every accumulator nibble >= 5, then shift {acc, shreg} left by one. After ADDR_W shifts, go to COMMIT.
  - COMMIT: if the ten-thousands nibble != 0, bcd_out = 16'h9999 and overflow = 1. Otherwise bcd_out = acc[15:0] and overflow = 0. Pulse done for one cycle, then go to IDLE.
- Latency: address accepted at edge T; done is high in cycle T+ADDR_W+1 (T+16 at the default); the next accept is possible at T+ADDR_W+2.
- Handshake: transfer occurs only when in_valid && in_ready. in_valid while busy is ignored with no queueing; the source must hold in_valid until accepted. in_valid in the COMMIT cycle is accepted in the following IDLE cycle.
- bcd_out, overflow and seg keep the previous value during conversion and change only in COMMIT.
- Scan: the prescaler counts 0..SCAN_DIV-1. At the terminal count it wraps to 0 and the scan index increments mod 4 (3 -> 0). digit_sel is registered one-hot of the index.
- seg = display_decoder(bcd_out nibble selected by index); this path is combinational from registers.
- With SCAN_DIV = 1 the index advances every cycle.
- Scan runs independently of the FSM and never stalls.
- Reset during CONVERT abandons the conversion: no done pulse, and the display returns to 0.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined: leading zero digits above the most significant nonzero digit output seg = SEG_BLANK. Units is never blanked, so a value of 0 shows a single "0". Blanking is evaluated on the committed bcd_out; 9999 saturation has no leading zeros.
- Undefined: all four digits are always decoded, with leading zeros shown.

Decomposition:
- Shared package disp_pkg:
  - FSM state encoding (IDLE, CONVERT, COMMIT).
  - NUM_DIGITS = 4.
  - BCD_SAT = 16'h9999.
  - SEG_BLANK segment code.
  - ADD3_THRESH = 5.
- Sub-module: a single instance of the existing display_decoder as the shared segment resource. The double-dabble step stays inline.

Test Plan:
- After reset with no input: digit_sel = 0001, bcd_out = 0000, in_ready = 1, no done pulse.
- address = 1234 with in_valid for one cycle at T: in_ready = 0 during T+1..T+16, done at T+16, bcd_out = 16'h1234, overflow = 0.
- address = 32767: bcd_out = 16'h9999, overflow = 1. A following address = 42 clears overflow and gives bcd_out = 16'h0042. With LEADING_ZERO_BLANK_EN, thousands and hundreds show SEG_BLANK.
- SCAN_DIV = 4, bcd_out = 16'h5678: digit_sel steps 0001 -> 0010 -> 0100 -> 1000 -> 0001 every 4 cycles, with seg = decode(8, 7, 6, 5) respectively.
- Accept 9999, then assert in_valid with 1111 throughout busy: only 9999 is converted. 1111 is accepted on the first IDLE cycle and done follows 16 cycles later.
- Accept 5000, assert reset at T+8 for one cycle: no done pulse, bcd_out = 0000, digit_sel = 0001, in_ready = 1 on the next cycle.
